// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the synchronous FIFO slice.
//   fifo_mode_e  - read-port flavour (registered read or first-word-fall-through)
//   ptr_w()      - index width for a given depth
//   cnt_w()      - occupancy counter width for a given depth (must hold DEPTH itself)
package fifo_pkg;

   typedef enum logic [0:0] {
      FIFO_REG  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Guarded so an illegal depth still elaborates far enough to report its $error.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH storage array for fifo_sync_param.
//   clk    in   clock
//   we     in   write enable (sync write on posedge)
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index (asynchronous read)
//   rdata  out  read data
// The array is intentionally not reset; occupancy tracking lives in the parent.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock elastic buffer with programmable level flags and sticky errors.
//   clk, rst                 clock and synchronous active-high reset
//   fifo_write, data_in      write request and data (ignored while full)
//   fifo_read                read request; in FWFT mode this acknowledges the head word
//   data_out, rd_valid       read data; rd_valid pulses (registered mode) or tracks !fifo_empty
//   err_clr                  clears overflow/underflow (a same-cycle new error wins)
//   fifo_full, fifo_empty    cnt == DEPTH / cnt == 0
//   almost_full/empty        cnt >= AF_LEVEL / cnt <= AE_LEVEL
//   overflow, underflow      sticky: write while full / read while empty
//   wr_ptr, rd_ptr, cnt      internal state exposed for property checkers
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = 14,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 0,
   localparam int unsigned PTR_W   = ptr_w(DEPTH),
   localparam int unsigned CNT_W   = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_write,
   input  logic [WIDTH-1:0] data_in,
   input  logic             fifo_read,
   output logic [WIDTH-1:0] data_out,
   output logic             rd_valid,
   input  logic             err_clr,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] cnt
);

   localparam fifo_mode_e       MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

   if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
   end
   if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
   end

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] ram_rdata;

   // Flags decode registered count only, so no input reaches a flag combinationally.
   assign fifo_full    = (cnt_q == CNT_FULL);
   assign fifo_empty   = (cnt_q == '0);
   assign almost_full  = (cnt_q >= AF_C);
   assign almost_empty = (cnt_q <= AE_C);

   assign wr_acc = fifo_write & ~fifo_full;
   assign rd_acc = fifo_read & ~fifo_empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      // Explicit wrap so non-power-of-two depths work.
      if (wr_acc) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end

      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // A new error in the same cycle as err_clr stays set.
      if (fifo_write && fifo_full) begin
         overflow_d = 1'b1;
      end else if (err_clr) begin
         overflow_d = 1'b0;
      end
      if (fifo_read && fifo_empty) begin
         underflow_d = 1'b1;
      end else if (err_clr) begin
         underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign wr_ptr    = wr_ptr_q;
   assign rd_ptr    = rd_ptr_q;
   assign cnt       = cnt_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly; a write shows up once cnt has registered it.
      assign data_out = ram_rdata;
      assign rd_valid = ~fifo_empty;
   end else begin : g_reg
      logic [WIDTH-1:0] data_out_q;
      logic             rd_valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
               data_out_q <= ram_rdata;
            end
         end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives one registered-read and one FWFT instance with identical stimulus and compares both
// against a queue-based reference model every cycle.
module tb_fifo_sync_param;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned AF    = 4;
   localparam int unsigned AE    = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic             fifo_write = 1'b0;
   logic             fifo_read = 1'b0;
   logic             err_clr = 1'b0;
   logic [WIDTH-1:0] data_in = '0;

   logic [WIDTH-1:0] r_dout, f_dout;
   logic             r_vld, f_vld;
   logic             r_full, r_empty, r_af, r_ae, r_ov, r_un;
   logic             f_full, f_empty, f_af, f_ae, f_ov, f_un;
   logic [2:0]       r_wp, r_rp, r_cnt, f_wp, f_rp, f_cnt;

   fifo_sync_param #(
      .WIDTH (WIDTH), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (0)
   ) u_reg (
      .clk (clk), .rst (rst), .fifo_write (fifo_write), .data_in (data_in),
      .fifo_read (fifo_read), .data_out (r_dout), .rd_valid (r_vld), .err_clr (err_clr),
      .fifo_full (r_full), .fifo_empty (r_empty), .almost_full (r_af), .almost_empty (r_ae),
      .overflow (r_ov), .underflow (r_un), .wr_ptr (r_wp), .rd_ptr (r_rp), .cnt (r_cnt)
   );

   fifo_sync_param #(
      .WIDTH (WIDTH), .DEPTH (DEPTH), .AF_LEVEL (AF), .AE_LEVEL (AE), .FWFT (1)
   ) u_fwft (
      .clk (clk), .rst (rst), .fifo_write (fifo_write), .data_in (data_in),
      .fifo_read (fifo_read), .data_out (f_dout), .rd_valid (f_vld), .err_clr (err_clr),
      .fifo_full (f_full), .fifo_empty (f_empty), .almost_full (f_af), .almost_empty (f_ae),
      .overflow (f_ov), .underflow (f_un), .wr_ptr (f_wp), .rd_ptr (f_rp), .cnt (f_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents as a queue, indices as modular counters.
   logic [WIDTH-1:0] q[$];
   int               m_wp = 0;
   int               m_rp = 0;
   bit               m_ov = 1'b0;
   bit               m_un = 1'b0;
   logic [WIDTH-1:0] m_dout = '0;
   bit               m_vld = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input bit w, input logic [WIDTH-1:0] d, input bit r,
                             input bit clr, input bit rs);
      bit full, empty;
      if (rs) begin
         q.delete();
         m_wp = 0; m_rp = 0; m_ov = 0; m_un = 0; m_dout = '0; m_vld = 0;
         return;
      end
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (r && !empty) begin
         m_dout = q.pop_front();
         m_vld  = 1'b1;
         m_rp   = (m_rp + 1) % DEPTH;
      end else begin
         m_vld = 1'b0;
      end
      if (w && !full) begin
         q.push_back(d);
         m_wp = (m_wp + 1) % DEPTH;
      end
      if (w && full) m_ov = 1'b1;
      else if (clr)  m_ov = 1'b0;
      if (r && empty) m_un = 1'b1;
      else if (clr)   m_un = 1'b0;
   endtask

   task automatic check_common(input string p, input logic [2:0] wp, input logic [2:0] rp,
                               input logic [2:0] cnt, input logic full, input logic empty,
                               input logic af, input logic ae, input logic ov, input logic un);
      int n;
      n = q.size();
      check({p, ".wr_ptr"}, 32'(wp), m_wp);
      check({p, ".rd_ptr"}, 32'(rp), m_rp);
      check({p, ".cnt"}, 32'(cnt), n);
      check({p, ".full"}, 32'(full), 32'(n == DEPTH));
      check({p, ".empty"}, 32'(empty), 32'(n == 0));
      check({p, ".almost_full"}, 32'(af), 32'(n >= AF));
      check({p, ".almost_empty"}, 32'(ae), 32'(n <= AE));
      check({p, ".overflow"}, 32'(ov), 32'(m_ov));
      check({p, ".underflow"}, 32'(un), 32'(m_un));
   endtask

   task automatic check_all();
      check_common("reg", r_wp, r_rp, r_cnt, r_full, r_empty, r_af, r_ae, r_ov, r_un);
      check_common("fwft", f_wp, f_rp, f_cnt, f_full, f_empty, f_af, f_ae, f_ov, f_un);
      check("reg.rd_valid", 32'(r_vld), 32'(m_vld));
      check("reg.data_out", 32'(r_dout), 32'(m_dout));
      check("fwft.rd_valid", 32'(f_vld), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("fwft.data_out", 32'(f_dout), 32'(q[0]));
      end
   endtask

   // One clock: drive away from the edge, update the model at the edge, sample 1 ns later.
   task automatic cycle(input bit w, input logic [WIDTH-1:0] d, input bit r,
                        input bit clr, input bit rs);
      fifo_write = w;
      data_in    = d;
      fifo_read  = r;
      err_clr    = clr;
      rst        = rs;
      @(posedge clk);
      model_step(w, d, r, clr, rs);
      #1;
      check_all();
   endtask

   initial begin
      // Reset
      cycle(0, 8'h00, 0, 0, 1);
      cycle(0, 8'h00, 0, 0, 1);

      // Fill 0x11..0x55, overflow with 0x66, drain in order
      for (int i = 1; i <= 5; i++) cycle(1, 8'(i * 17), 0, 0, 0);
      cycle(1, 8'h66, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // Wrap at steady occupancy of two
      cycle(0, 8'h00, 0, 1, 0);
      cycle(1, 8'hA0, 0, 0, 0);
      cycle(1, 8'hA1, 0, 0, 0);
      for (int i = 0; i < 7; i++) cycle(1, 8'(8'hB0 + i), 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);

      // Full + write + read
      cycle(0, 8'h00, 0, 0, 1);
      for (int i = 1; i <= 5; i++) cycle(1, 8'(i * 17), 0, 0, 0);
      cycle(1, 8'h77, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);

      // Empty + write + read, then clear; set beats clear in the same cycle
      cycle(1, 8'h88, 1, 0, 0);
      cycle(0, 8'h00, 0, 1, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 1, 1, 0);
      cycle(0, 8'h00, 0, 1, 0);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
      cycle(0, 8'h00, 0, 0, 1);
      cycle(1, 8'h99, 0, 0, 0);
      cycle(0, 8'h00, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 0);

      // Randomized phases alternating write-heavy and read-heavy traffic
      for (int ph = 0; ph < 8; ph++) begin
         int wp_pct;
         wp_pct = (ph % 2 == 0) ? 75 : 25;
         for (int i = 0; i < 250; i++) begin
            bit w, r, c, rs;
            w  = ($urandom_range(0, 99) < wp_pct);
            r  = ($urandom_range(0, 99) < (100 - wp_pct));
            c  = ($urandom_range(0, 99) < 5);
            rs = ($urandom_range(0, 999) < 5);
            cycle(w, 8'($urandom), r, c, rs);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
